conv_compute: RTL

Downstream consumer of the input-memory stage. Once that stage reports complete X, W, K and B, this block walks every valid KxK window of the RxC input X. For each window it issues reads to the X and W memories, multiply-accumulates the products onto bias B, and emits each output Y[r][c] on an AXI-Stream master interface. After the last output is accepted it pulses compute_finished so the input stage can accept the next job.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_addr_gen.sv | 76 +++++++
 rtl/conv_compute.sv | 136 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution datapath and the
// input-memory stage that feeds it.
package conv_pkg;

  typedef logic [2:0] conv_state_t;

  localparam conv_state_t StIdle  = 3'd0;
  localparam conv_state_t StInit  = 3'd1;
  localparam conv_state_t StMac   = 3'd2;
  localparam conv_state_t StDrain = 3'd3;
  localparam conv_state_t StOut   = 3'd4;
  localparam conv_state_t StDone  = 3'd5;

  function automatic int unsigned k_bits(input int unsigned maxk);
    return $clog2(maxk + 1);
  endfunction

  function automatic int unsigned x_addr_bits(input int unsigned rows, input int unsigned cols);
    return $clog2(rows * cols);
  endfunction

  function automatic int unsigned w_addr_bits(input int unsigned maxk);
    return $clog2(maxk * maxk);
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Window (r, c) and kernel-tap (i, j) counters with X/W read address generation.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int unsigned R    = 15,
  parameter int unsigned C    = 13,
  parameter int unsigned MAXK = 7,
  localparam int unsigned K_BITS      = k_bits(MAXK),
  localparam int unsigned X_ADDR_BITS = x_addr_bits(R, C),
  localparam int unsigned W_ADDR_BITS = w_addr_bits(MAXK)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   step,
  input  logic                   next_window,
  input  logic [K_BITS-1:0]      k,
  output logic [X_ADDR_BITS-1:0] x_addr,
  output logic [W_ADDR_BITS-1:0] w_addr,
  output logic                   last_tap,
  output logic                   last_window
);

  logic [X_ADDR_BITS-1:0] r;
  logic [X_ADDR_BITS-1:0] c;
  logic [K_BITS-1:0]      i;
  logic [K_BITS-1:0]      j;

  logic [K_BITS-1:0]      k_last;
  logic [X_ADDR_BITS-1:0] k_x;
  logic [X_ADDR_BITS-1:0] r_last;
  logic [X_ADDR_BITS-1:0] c_last;
  logic [X_ADDR_BITS-1:0] row;
  logic [X_ADDR_BITS-1:0] col;

  assign k_last = k - K_BITS'(1);
  assign k_x    = X_ADDR_BITS'(k);
  // Top-left corner of the final window in each dimension.
  assign r_last = X_ADDR_BITS'(R) - k_x;
  assign c_last = X_ADDR_BITS'(C) - k_x;

  assign last_tap    = (i == k_last) && (j == k_last);
  assign last_window = (r == r_last) && (c == c_last);

  assign row    = r + X_ADDR_BITS'(i);
  assign col    = c + X_ADDR_BITS'(j);
  assign x_addr = row * X_ADDR_BITS'(C) + col;
  assign w_addr = W_ADDR_BITS'(i) * W_ADDR_BITS'(k) + W_ADDR_BITS'(j);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r <= '0;
      c <= '0;
      i <= '0;
      j <= '0;
    end else begin
      if (step) begin
        if (j == k_last) begin
          j <= '0;
          i <= (i == k_last) ? '0 : i + K_BITS'(1);
        end else begin
          j <= j + K_BITS'(1);
        end
      end
      if (next_window) begin
        if (c != c_last) begin
          c <= c + X_ADDR_BITS'(1);
        end else begin
          c <= '0;
          r <= r + X_ADDR_BITS'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv_compute.sv
// Walks every KxK window of X, multiply-accumulates against W on top of bias B
// and streams each result out over AXI-Stream.
module conv_compute
  import conv_pkg::*;
#(
  parameter int unsigned INW  = 10,
  parameter int unsigned R    = 15,
  parameter int unsigned C    = 13,
  parameter int unsigned MAXK = 7,
  parameter int unsigned OUTW = 32,
  localparam int unsigned K_BITS      = k_bits(MAXK),
  localparam int unsigned X_ADDR_BITS = x_addr_bits(R, C),
  localparam int unsigned W_ADDR_BITS = w_addr_bits(MAXK)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inputs_loaded,
  input  logic [K_BITS-1:0]      K,
  input  logic signed [INW-1:0]  B,
  output logic [X_ADDR_BITS-1:0] X_read_addr,
  input  logic signed [INW-1:0]  X_data,
  output logic [W_ADDR_BITS-1:0] W_read_addr,
  input  logic signed [INW-1:0]  W_data,
  output logic                   compute_finished,
  output logic signed [OUTW-1:0] AXIS_TDATA_OUT,
  output logic                   AXIS_TVALID_OUT,
  input  logic                   AXIS_TREADY_IN
);

  conv_state_t state_q;
  conv_state_t state_d;

  logic [K_BITS-1:0]      k_q;
  logic signed [OUTW-1:0] acc_q;
  logic                   a_vld_q;   // address register holds a live tap
  logic                   d_vld_q;   // memory data holds a live tap
  logic                   issued_q;  // last tap address already on the port

  logic                   step;
  logic                   next_window;
  logic                   last_tap;
  logic                   last_window;
  logic [X_ADDR_BITS-1:0] x_addr;
  logic [W_ADDR_BITS-1:0] w_addr;

  logic signed [2*INW-1:0] x_ext;
  logic signed [2*INW-1:0] w_ext;
  logic signed [2*INW-1:0] prod;
  logic signed [OUTW-1:0]  prod_ext;
  logic signed [OUTW-1:0]  bias_ext;
  logic signed [OUTW-1:0]  acc_sum;

  assign x_ext    = {{INW{X_data[INW-1]}}, X_data};
  assign w_ext    = {{INW{W_data[INW-1]}}, W_data};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(OUTW-2*INW){prod[2*INW-1]}}, prod};
  assign bias_ext = {{(OUTW-INW){B[INW-1]}}, B};
  assign acc_sum  = d_vld_q ? acc_q + prod_ext : acc_q;

  assign step        = (state_q == StInit) || ((state_q == StMac) && !issued_q);
  assign next_window = (state_q == StOut) && AXIS_TREADY_IN && !last_window;

  assign compute_finished = (state_q == StDone);

  conv_addr_gen #(
    .R    (R),
    .C    (C),
    .MAXK (MAXK)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .clear       (state_q == StIdle),
    .step        (step),
    .next_window (next_window),
    .k           (k_q),
    .x_addr      (x_addr),
    .w_addr      (w_addr),
    .last_tap    (last_tap),
    .last_window (last_window)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (inputs_loaded) state_d = StInit;
      StInit:  state_d = StMac;
      StMac:   if (issued_q) state_d = StDrain;
      StDrain: state_d = StOut;
      StOut:   if (AXIS_TREADY_IN) state_d = last_window ? StDone : StInit;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      k_q             <= '0;
      acc_q           <= '0;
      a_vld_q         <= 1'b0;
      d_vld_q         <= 1'b0;
      issued_q        <= 1'b0;
      X_read_addr     <= '0;
      W_read_addr     <= '0;
      AXIS_TDATA_OUT  <= '0;
      AXIS_TVALID_OUT <= 1'b0;
    end else begin
      state_q <= state_d;
      // Two-stage pipe: address issued -> address on port -> data returned.
      a_vld_q <= step;
      d_vld_q <= a_vld_q;
      if (step) begin
        X_read_addr <= x_addr;
        W_read_addr <= w_addr;
      end
      case (state_q)
        StIdle: if (inputs_loaded) k_q <= K;
        StInit: begin
          acc_q    <= bias_ext;
          issued_q <= 1'b0;
        end
        StMac: begin
          acc_q <= acc_sum;
          if (step && last_tap) issued_q <= 1'b1;
        end
        StDrain: begin
          AXIS_TDATA_OUT  <= acc_sum;
          AXIS_TVALID_OUT <= 1'b1;
        end
        StOut: if (AXIS_TREADY_IN) AXIS_TVALID_OUT <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
